hawk_axird_arb: RTL and testbench

//  Round-robin arbiter that shares the single hawk_axird_master between NUM_REQ read requesters
//  (ATT/ToL lookup, compression manager, decompression manager).

---
 rtl/hawk_axird_arb_pkg.sv | 45 ++++
 rtl/hawk_axird_arb_if.sv | 27 ++
 rtl/hawk_rr_picker.sv | 35 +++
 rtl/hawk_axird_arb.sv | 154 +++++++++++++++
 tb/tb_hawk_axird_arb.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/hawk_axird_arb_pkg.sv
// Shared types for the AXI read arbiter: request/ready/response packets, FSM states and debug view.
package hawk_axird_arb_pkg;

    localparam int AXI4_LEN_W    = 8;
    localparam int AXI_ADDR_W    = 48;
    localparam int AXI_DATA_W    = 64;
    localparam int AXIRD_NUM_REQ = 3;
    localparam int AXIRD_BEAT_W  = AXI4_LEN_W + 1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } axird_arb_state_t;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI4_LEN_W-1:0] arlen;
        logic                  arvalid;
        logic                  rready;
    } axi_rd_reqpkt_t;

    typedef struct packed {
        logic arready;
    } axi_rd_rdypkt_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rvalid;
        logic                  rlast;
    } axi_rd_resppkt_t;

    typedef struct packed {
        axird_arb_state_t          state;
        logic [2:0]                grant_idx;
        logic [AXIRD_BEAT_W-1:0]   beat_cnt;
        logic                      len_err;
    } debug_axird_arb_t;

    function automatic int rr_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/hawk_axird_arb_if.sv
// Bundle of requester-side and master-side read channels shared by the arbiter.
interface hawk_axird_arb_if
    import hawk_axird_arb_pkg::*;
#(
    parameter int NUM_REQ = AXIRD_NUM_REQ
);

    axi_rd_reqpkt_t  req_pkt  [NUM_REQ];
    axi_rd_rdypkt_t  req_rdy  [NUM_REQ];
    axi_rd_resppkt_t req_resp [NUM_REQ];
    axi_rd_reqpkt_t  mst_req;
    axi_rd_rdypkt_t  mst_rdy;
    axi_rd_resppkt_t mst_resp;

    // Arbiter side
    modport slave (
        input  req_pkt, mst_rdy, mst_resp,
        output req_rdy, req_resp, mst_req
    );

    // Requesters plus read master side
    modport master (
        output req_pkt, mst_rdy, mst_resp,
        input  req_rdy, req_resp, mst_req
    );

endinterface

// File: rtl/hawk_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module hawk_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_oh_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_req_o
);

    int   cand;
    logic found;

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req_i[cand]) begin
                found            = 1'b1;
                grant_oh_o[cand] = 1'b1;
                grant_idx_o      = IDX_W'(cand);
            end
        end
        any_req_o = |req_i;
    end

endmodule

// File: rtl/hawk_axird_arb.sv
// Round-robin arbiter sharing one AXI read master; one burst in flight, locked to its winner until rlast.
module hawk_axird_arb
    import hawk_axird_arb_pkg::*;
#(
    parameter int NUM_REQ = AXIRD_NUM_REQ
) (
    input  logic             clk,
    input  logic             rst_n,
    hawk_axird_arb_if.slave  bus,
    output debug_axird_arb_t dbg
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = AXIRD_BEAT_W;

    axird_arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
    logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic                    len_err_q, len_err_d;
    logic [AXI_ADDR_W-1:0]   addr_q, addr_d;
    logic [AXI4_LEN_W-1:0]   arlen_q, arlen_d;

    logic [NUM_REQ-1:0]      req_vec;
    logic [NUM_REQ-1:0]      rready_vec;
    logic [NUM_REQ-1:0]      gnt_sel;
    logic [NUM_REQ-1:0]      grant_oh;
    logic [IDX_W-1:0]        win_idx;
    logic                    any_req;
    logic                    gnt_rready;
    logic [AXI_ADDR_W-1:0]   win_addr;
    logic [AXI4_LEN_W-1:0]   win_len;
    logic [BEAT_W-1:0]       beat_cnt_inc;
    logic [BEAT_W-1:0]       exp_beats;
    logic                    beat;
    axi_rd_reqpkt_t          mst_req;

    // Requests are masked during reset so no arready pulse escapes while rst_n is low.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_vec[gi]    = bus.req_pkt[gi].arvalid & rst_n;
        assign rready_vec[gi] = bus.req_pkt[gi].rready;
        assign gnt_sel[gi]    = (state_q == ARB_DATA) && (grant_idx_q == IDX_W'(gi));
        assign bus.req_rdy[gi] = '{arready: (state_q == ARB_IDLE) & grant_oh[gi]};
        assign bus.req_resp[gi] = '{rdata:  bus.mst_resp.rdata,
                                    rresp:  bus.mst_resp.rresp,
                                    rvalid: gnt_sel[gi] & bus.mst_resp.rvalid,
                                    rlast:  gnt_sel[gi] & bus.mst_resp.rlast};
    end

    hawk_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i       (req_vec),
        .ptr_i       (rr_ptr_q),
        .grant_oh_o  (grant_oh),
        .grant_idx_o (win_idx),
        .any_req_o   (any_req)
    );

    always_comb begin
        win_addr = '0;
        win_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                win_addr = bus.req_pkt[i].addr;
                win_len  = bus.req_pkt[i].arlen;
            end
        end
    end

    assign gnt_rready   = |(gnt_sel & rready_vec);
    assign beat_cnt_inc = beat_cnt_q + BEAT_W'(1);
    // Zero-extended so arlen=255 yields 256 without wrapping.
    assign exp_beats    = {1'b0, arlen_q} + BEAT_W'(1);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        beat_cnt_d  = beat_cnt_q;
        len_err_d   = len_err_q;
        addr_d      = addr_q;
        arlen_d     = arlen_q;
        mst_req     = '0;
        beat        = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    state_d     = ARB_ADDR;
                    grant_idx_d = win_idx;
                    rr_ptr_d    = IDX_W'(rr_wrap_inc(int'(win_idx), NUM_REQ));
                    beat_cnt_d  = '0;
                    addr_d      = win_addr;
                    arlen_d     = win_len;
                end
            end
            ARB_ADDR: begin
                mst_req.addr    = addr_q;
                mst_req.arlen   = arlen_q;
                mst_req.arvalid = 1'b1;
                if (bus.mst_rdy.arready) begin
                    state_d = ARB_DATA;
                end
            end
            ARB_DATA: begin
                mst_req.addr   = addr_q;
                mst_req.arlen  = arlen_q;
                mst_req.rready = gnt_rready;
                beat           = bus.mst_resp.rvalid & gnt_rready;
                if (beat) begin
                    beat_cnt_d = beat_cnt_inc;
                    if (bus.mst_resp.rlast != (beat_cnt_inc == exp_beats)) begin
                        len_err_d = 1'b1;
                    end
                    if (bus.mst_resp.rlast) begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign bus.mst_req = mst_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            beat_cnt_q  <= '0;
            len_err_q   <= 1'b0;
            addr_q      <= '0;
            arlen_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            len_err_q   <= len_err_d;
            addr_q      <= addr_d;
            arlen_q     <= arlen_d;
        end
    end

    assign dbg = '{state:     state_q,
                   grant_idx: 3'(grant_idx_q),
                   beat_cnt:  beat_cnt_q,
                   len_err:   len_err_q};

endmodule

// File: tb/tb_hawk_axird_arb.sv
// Directed bench for hawk_axird_arb: grant timing, rotation, backpressure, isolation, length error, reset.
module tb_hawk_axird_arb;
    import hawk_axird_arb_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    debug_axird_arb_t dbg;
    int               n_vec = 0;
    int               n_err = 0;
    bit               m_len_err = 1'b0;

    hawk_axird_arb_if #(.NUM_REQ(3)) bus ();

    hawk_axird_arb #(.NUM_REQ(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .dbg   (dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] beat_data(input int r, input int b);
        return 64'hD000_0000_0000_0000 | (64'(r) << 8) | 64'(b);
    endfunction

    task automatic set_req(input int r, input logic [47:0] a, input logic [7:0] len, input logic v);
        bus.req_pkt[r].addr    = a;
        bus.req_pkt[r].arlen   = len;
        bus.req_pkt[r].arvalid = v;
        bus.req_pkt[r].rready  = 1'b1;
    endtask

    // No arready anywhere and no response leaks to non-granted requesters.
    task automatic iso(input int r);
        for (int j = 0; j < 3; j++) begin
            chk_vec($sformatf("arready%0d_busy", j), 64'(bus.req_rdy[j].arready), 64'd0);
            if (j != r) begin
                chk_vec($sformatf("rvalid%0d_iso", j), 64'(bus.req_resp[j].rvalid), 64'd0);
                chk_vec($sformatf("rlast%0d_iso", j), 64'(bus.req_resp[j].rlast), 64'd0);
            end
        end
    endtask

    // Called in IDLE with requests already driven: arready pulse same cycle, ADDR next.
    task automatic grant(input int r);
        #1;
        chk_vec("state_idle_at_grant", 64'(dbg.state), 64'(ARB_IDLE));
        for (int j = 0; j < 3; j++) begin
            chk_vec($sformatf("arready%0d_pulse", j), 64'(bus.req_rdy[j].arready), (j == r) ? 64'd1 : 64'd0);
        end
        chk_vec("mst_arvalid_in_idle", 64'(bus.mst_req.arvalid), 64'd0);
        tick();
        chk_vec("state_addr", 64'(dbg.state), 64'(ARB_ADDR));
        chk_vec("grant_idx", 64'(dbg.grant_idx), 64'(r));
    endtask

    // Plays the read master for one granted burst.
    task automatic serve(input int r, input logic [47:0] a, input logic [7:0] len, input int nb,
                         input bit term, input int aw_wait, input int stall_beat, input int stall_n);
        logic rl;
        for (int w = 0; w <= aw_wait; w++) begin
            chk_vec("state_addr_hold", 64'(dbg.state), 64'(ARB_ADDR));
            bus.mst_rdy.arready = (w == aw_wait);
            #1;
            chk_vec("mst_arvalid", 64'(bus.mst_req.arvalid), 64'd1);
            chk_vec("mst_addr", 64'(bus.mst_req.addr), 64'(a));
            chk_vec("mst_arlen", 64'(bus.mst_req.arlen), 64'(len));
            iso(r);
            tick();
        end
        bus.mst_rdy.arready = 1'b0;
        chk_vec("state_data", 64'(dbg.state), 64'(ARB_DATA));
        for (int b = 0; b < nb; b++) begin
            rl = term && (b == nb - 1);
            if (b == stall_beat) begin
                bus.req_pkt[r].rready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    bus.mst_resp = '{rdata: beat_data(r, b), rresp: 2'b00, rvalid: 1'b1, rlast: rl};
                    #1;
                    chk_vec("mst_rready_stall", 64'(bus.mst_req.rready), 64'd0);
                    chk_vec("rvalid_held", 64'(bus.req_resp[r].rvalid), 64'd1);
                    iso(r);
                    tick();
                    chk_vec("beat_cnt_frozen", 64'(dbg.beat_cnt), 64'(b));
                end
                bus.req_pkt[r].rready = 1'b1;
            end
            bus.mst_resp = '{rdata: beat_data(r, b), rresp: 2'b00, rvalid: 1'b1, rlast: rl};
            #1;
            chk_vec("rvalid_routed", 64'(bus.req_resp[r].rvalid), 64'd1);
            chk_vec("rdata_routed", bus.req_resp[r].rdata, beat_data(r, b));
            chk_vec("rlast_routed", 64'(bus.req_resp[r].rlast), 64'(rl));
            chk_vec("mst_rready", 64'(bus.mst_req.rready), 64'd1);
            iso(r);
            tick();
            bus.mst_resp = '0;
            chk_vec("beat_cnt", 64'(dbg.beat_cnt), 64'(b + 1));
            if (rl != (b == int'(len))) begin
                m_len_err = 1'b1;
            end
        end
        if (term) begin
            chk_vec("state_bubble_idle", 64'(dbg.state), 64'(ARB_IDLE));
            chk_vec("mst_arvalid_bubble", 64'(bus.mst_req.arvalid), 64'd0);
        end else begin
            chk_vec("state_still_data", 64'(dbg.state), 64'(ARB_DATA));
        end
        chk_vec("len_err", 64'(dbg.len_err), 64'(m_len_err));
        $display("burst req=%0d addr=%0h arlen=%0d beats=%0d rlast=%0d len_err=%0d",
                 r, a, len, nb, term, m_len_err);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_vec({tag, "_state"}, 64'(dbg.state), 64'(ARB_IDLE));
        chk_vec({tag, "_grant"}, 64'(dbg.grant_idx), 64'd0);
        chk_vec({tag, "_beat_cnt"}, 64'(dbg.beat_cnt), 64'd0);
        chk_vec({tag, "_len_err"}, 64'(dbg.len_err), 64'd0);
        chk_vec({tag, "_mst_req"}, 64'(bus.mst_req), 64'd0);
        for (int j = 0; j < 3; j++) begin
            chk_vec($sformatf("%s_arready%0d", tag, j), 64'(bus.req_rdy[j].arready), 64'd0);
            chk_vec($sformatf("%s_rvalid%0d", tag, j), 64'(bus.req_resp[j].rvalid), 64'd0);
        end
    endtask

    initial begin
        int order [4] = '{0, 1, 2, 0};
        for (int j = 0; j < 3; j++) begin
            bus.req_pkt[j] = '0;
        end
        bus.mst_rdy  = '0;
        bus.mst_resp = '0;

        // Reset state, with a pending request that must not be acknowledged.
        repeat (3) @(posedge clk);
        #1;
        bus.req_pkt[0].arvalid = 1'b1;
        #1;
        chk_all_zero("rst");
        bus.req_pkt[0].arvalid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk_all_zero("post_rst");

        // Contention: all three continuously requesting arlen=3.
        for (int j = 0; j < 3; j++) begin
            set_req(j, 48'h1000 * 48'(j + 1), 8'd3, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            grant(order[k]);
            serve(order[k], 48'h1000 * 48'(order[k] + 1), 8'd3, 4, 1'b1, 0, -1, 0);
        end
        for (int j = 0; j < 3; j++) begin
            bus.req_pkt[j].arvalid = 1'b0;
        end
        tick();
        chk_vec("idle_after_drop", 64'(dbg.state), 64'(ARB_IDLE));

        // Single beat from requester 1.
        set_req(1, 48'hFFF6200040, 8'd0, 1'b1);
        grant(1);
        bus.req_pkt[1].arvalid = 1'b0;
        serve(1, 48'hFFF6200040, 8'd0, 1, 1'b1, 0, -1, 0);

        // Backpressure on AR and R for requester 2 while requester 0 knocks.
        set_req(2, 48'h2_0000_0100, 8'd3, 1'b1);
        grant(2);
        bus.req_pkt[2].arvalid = 1'b0;
        set_req(0, 48'h3_0000_0000, 8'd3, 1'b1);
        serve(2, 48'h2_0000_0100, 8'd3, 4, 1'b1, 5, 1, 3);

        // Length error: arlen=3 but rlast on the second beat.
        grant(0);
        bus.req_pkt[0].arvalid = 1'b0;
        serve(0, 48'h3_0000_0000, 8'd3, 2, 1'b1, 0, -1, 0);

        // Next grant proceeds, then reset after its first beat.
        set_req(1, 48'h4000, 8'd3, 1'b1);
        grant(1);
        bus.req_pkt[1].arvalid = 1'b0;
        serve(1, 48'h4000, 8'd3, 1, 1'b0, 0, -1, 0);
        rst_n = 1'b0;
        set_req(0, 48'h5000, 8'd0, 1'b1);
        set_req(2, 48'h6000, 8'd0, 1'b1);
        bus.mst_resp = '{rdata: 64'hDEAD, rresp: 2'b00, rvalid: 1'b1, rlast: 1'b0};
        m_len_err = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        tick();
        chk_all_zero("mid_rst_hold");
        bus.mst_resp = '0;
        rst_n = 1'b1;
        grant(0);
        bus.req_pkt[0].arvalid = 1'b0;
        bus.req_pkt[2].arvalid = 1'b0;
        serve(0, 48'h5000, 8'd0, 1, 1'b1, 0, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
